// File: rtl/branch_issue_sched_pkg.sv
// Shared types and constants for the branch reservation station.
// ROB tags carry a spare MSB; only the low ROB_IDX_W bits take part in age/flush math.
package branch_issue_sched_pkg;

   localparam int ROB_TAG_W = 5;
   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
   localparam int RS_PREG_W = 7;

   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_BNE     = 3'b001;

   typedef struct packed {
      logic [6:0]           opcode;
      logic [2:0]           func3;
      logic [31:0]          imm;
      logic [31:0]          pc;
      logic [RS_PREG_W-1:0] pd;
      logic [RS_PREG_W-1:0] ps1;
      logic [RS_PREG_W-1:0] ps2;
      logic                 ps1_ready;
      logic                 ps2_ready;
      logic [ROB_TAG_W-1:0] rob_index;
   } rs_data;

   // True when idx lies in the circular window [start, stop).
   function automatic logic flush_hit(input logic [ROB_IDX_W-1:0] idx,
                                      input logic [ROB_IDX_W-1:0] start,
                                      input logic [ROB_IDX_W-1:0] stop);
      logic [ROB_IDX_W-1:0] d_idx;
      logic [ROB_IDX_W-1:0] d_stop;
      d_idx  = idx - start;
      d_stop = stop - start;
      return d_idx < d_stop;
   endfunction

endpackage

// File: rtl/branch_issue_sched_age_select.sv
// Oldest-ready picker: smallest (rob_index - rob_head) mod 16 among ready entries,
// lowest slot index on a tie.
module age_select
   import branch_issue_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]                valid_i,
   input  logic [DEPTH-1:0]                ready_i,
   input  logic [DEPTH-1:0][ROB_TAG_W-1:0] rob_index_i,
   input  logic [ROB_TAG_W-1:0]            rob_head_i,
   output logic                            sel_valid_o,
   output logic [IDX_W-1:0]                sel_idx_o
);

   logic                 found;
   logic [IDX_W-1:0]     best_idx;
   logic [ROB_IDX_W-1:0] best_age;
   logic [ROB_IDX_W-1:0] age;
   logic                 unused_tag_msbs;

   always_comb begin
      found    = 1'b0;
      best_idx = '0;
      best_age = '0;
      age      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age = rob_index_i[i][ROB_IDX_W-1:0] - rob_head_i[ROB_IDX_W-1:0];
         if (valid_i[i] && ready_i[i] && (!found || age < best_age)) begin
            found    = 1'b1;
            best_idx = IDX_W'(i);
            best_age = age;
         end
      end
   end

   always_comb begin
      unused_tag_msbs = rob_head_i[ROB_TAG_W-1];
      for (int i = 0; i < DEPTH; i++) begin
         unused_tag_msbs = unused_tag_msbs ^ rob_index_i[i][ROB_TAG_W-1];
      end
   end

   assign sel_valid_o = found;
   assign sel_idx_o   = best_idx;

endmodule

// File: rtl/branch_issue_sched.sv
// Branch-unit reservation station: dispatch into the lowest free slot, tag wakeup
// (with dispatch-cycle bypass), oldest-ready issue and mispredict squash.
module branch_issue_sched
   import branch_issue_sched_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int N_WB   = 3,
   parameter int PREG_W = RS_PREG_W
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         disp_valid_i,
   input  rs_data                       disp_data_i,
   output logic                         disp_ready_o,
   input  logic [N_WB-1:0]              wb_valid_i,
   input  logic [N_WB-1:0][PREG_W-1:0]  wb_tag_i,
   input  logic                         fu_b_ready_i,
   input  logic [ROB_TAG_W-1:0]         rob_head_i,
   input  logic [ROB_TAG_W-1:0]         curr_rob_tag_i,
   input  logic                         mispredict_i,
   input  logic [ROB_TAG_W-1:0]         mispredict_tag_i,
   output logic                         issued_o,
   output rs_data                       issue_data_o,
   output logic [$clog2(DEPTH):0]       occupancy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0] valid_q, valid_d;
   rs_data           data_q [DEPTH];
   rs_data           data_d [DEPTH];
   logic             issued_q;
   rs_data           issue_data_q;

   logic [DEPTH-1:0]                ready_vec;
   logic [DEPTH-1:0][ROB_TAG_W-1:0] rob_vec;
   logic                            sel_valid;
   logic [IDX_W-1:0]                sel_idx;
   logic                            issue_fire;
   logic [IDX_W-1:0]                free_idx;
   logic                            free_found;
   logic                            disp_fire;
   logic [CNT_W-1:0]                occ;
   logic [ROB_IDX_W-1:0]            flush_start;
   logic                            unused_tag_msbs;

   function automatic logic tag_hit(input logic [PREG_W-1:0] tag);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < N_WB; k++) begin
         if (wb_valid_i[k] && wb_tag_i[k] == tag) hit = 1'b1;
      end
      return hit;
   endfunction

   // Selection looks only at stored ready bits, so a wakeup costs one cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = valid_q[i] && data_q[i].ps1_ready && data_q[i].ps2_ready;
         rob_vec[i]   = data_q[i].rob_index;
      end
   end

   age_select #(.DEPTH(DEPTH)) u_age_select (
      .valid_i     (valid_q),
      .ready_i     (ready_vec),
      .rob_index_i (rob_vec),
      .rob_head_i  (rob_head_i),
      .sel_valid_o (sel_valid),
      .sel_idx_o   (sel_idx)
   );

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      occ        = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
         occ = occ + CNT_W'(valid_q[i]);
      end
   end

   assign issue_fire   = sel_valid && fu_b_ready_i && !mispredict_i;
   assign disp_ready_o = free_found && !mispredict_i;
   assign disp_fire    = disp_valid_i && disp_ready_o;
   assign flush_start  = mispredict_tag_i[ROB_IDX_W-1:0] + 1'b1;

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i]           = data_q[i];
         data_d[i].ps1_ready = data_q[i].ps1_ready | tag_hit(data_q[i].ps1);
         data_d[i].ps2_ready = data_q[i].ps2_ready | tag_hit(data_q[i].ps2);
         if (mispredict_i && flush_hit(data_q[i].rob_index[ROB_IDX_W-1:0], flush_start,
                                       curr_rob_tag_i[ROB_IDX_W-1:0])) begin
            valid_d[i] = 1'b0;
         end
         if (issue_fire && sel_idx == IDX_W'(i)) valid_d[i] = 1'b0;
      end
      if (disp_fire) begin
         valid_d[free_idx]           = 1'b1;
         data_d[free_idx]            = disp_data_i;
         data_d[free_idx].ps1_ready  = disp_data_i.ps1_ready | tag_hit(disp_data_i.ps1);
         data_d[free_idx].ps2_ready  = disp_data_i.ps2_ready | tag_hit(disp_data_i.ps2);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         valid_q      <= '0;
         issued_q     <= 1'b0;
         issue_data_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         valid_q  <= valid_d;
         issued_q <= issue_fire;
         if (issue_fire) issue_data_q <= data_q[sel_idx];
         for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      end
   end

   assign unused_tag_msbs = curr_rob_tag_i[ROB_TAG_W-1] ^ mispredict_tag_i[ROB_TAG_W-1];

   assign issued_o     = issued_q;
   assign issue_data_o = issue_data_q;
   assign occupancy_o  = occ;

endmodule

// File: doc/branch_issue_sched.md
# branch_issue_sched

Four-entry reservation station and issue scheduler for the branch functional unit. Accepts dispatched JALR/BNE micro-ops, tracks operand readiness through writeback tag broadcasts, and issues the oldest ready entry, at most one per cycle, to `fu_branch`. Squashes entries younger than a mispredicted branch. Sits between dispatch/rename and `fu_branch`; `issue_data.ps1`/`ps2` also drive the PRF read ports.

## Interface
- `DEPTH`, 4: entry count (power of two, 2..8)
- `N_WB`, 3: writeback broadcast ports
- `PREG_W`, 7: physical register tag width
- `clk` in 1: clock
- `reset` in 1: synchronous, active-low reset
- `disp_valid` in 1: dispatch offers a branch micro-op
- `disp_data` in `rs_data`: micro-op (opcode, func3, imm, pc, pd, ps1, ps2, ps1_ready, ps2_ready, rob_index)
- `disp_ready` out 1: slot free and no mispredict this cycle (combinational)
- `wb_valid` in `N_WB`: broadcast valid per port
- `wb_tag` in `N_WB`×`PREG_W`: produced physical register per port
- `fu_b_ready` in 1: `fu_branch` can accept
- `rob_head` in 5: oldest ROB tag, for age ordering
- `curr_rob_tag` in 5: next ROB allocation tag
- `mispredict` in 1: flush request
- `mispredict_tag` in 5: ROB tag of the mispredicted branch
- `issued` out 1: registered issue strobe to `fu_branch`
- `issue_data` out `rs_data`: registered issued micro-op
- `occupancy` out `$clog2(DEPTH)+1`: valid entry count

## Operation
- Entry = `valid` + `rs_data`. Dispatch accepted when `disp_valid && disp_ready`; written into the lowest-index free slot.
- Wakeup: each valid `wb_tag[k]` matching an entry's `ps1`/`ps2` sets the corresponding ready bit. Matching also applies to `disp_data` in the acceptance cycle (same-cycle bypass); an operand woken that way is stored as ready.
- Ready entry: `valid && ps1_ready && ps2_ready`. Readiness is evaluated from stored bits only: an entry woken in cycle N can issue in cycle N+1 at the earliest.
- Age = `(rob_index - rob_head) mod 16`. ROB tags span 0..15 only; bit 4 is ignored in every comparison. Select the ready entry with the smallest age; the lowest slot index breaks a tie.
- Issue when any entry is ready, `fu_b_ready=1` and `mispredict=0`. The selected entry is invalidated in the same edge.
- Flush on `mispredict`: the range starts at `(mispredict_tag==15)?0:mispredict_tag+1`, steps with wrap 15→0, and stops before `curr_rob_tag`. Every valid entry whose `rob_index` is in the range is invalidated. An empty range (start == `curr_rob_tag`) flushes nothing. The mispredicting branch itself is never flushed.
- During the mispredict cycle: no issue, no dispatch accepted (`disp_ready=0`). Wakeups still apply to surviving entries.
- Full: `disp_ready=0` when `occupancy==DEPTH`. A slot freed by issue becomes usable in the next cycle, not the same one.

## Timing
- Reset (`reset==0` at posedge): all entries invalid; `issued=0`; `issue_data='0`; `occupancy=0`; `disp_ready=1` once reset deasserts.
- Reset mid-operation discards all entries and any pending issue.
- Dispatch at edge N, both operands ready → `issued=1` after edge N+1 (one-cycle minimum RS latency).
- `issued` is a one-cycle pulse per micro-op. Back-to-back issue is allowed every cycle.
- `issue_data` holds its last value when `issued=0`; consumers qualify it with `issued`.
- `fu_b_ready=0` blocks selection. Entries keep their state.

## Structure
- Shared package: `rs_data` typedef (with the ps1/ps2 tags and ready bits), `ROB_TAG_W=5`, `ROB_DEPTH=16`, opcode constants for JALR/BNE.
- One sub-module: `age_select`. It takes valid/ready/rob_index vectors plus `rob_head` and returns `sel_valid` and `sel_idx`, combinationally. Wakeup, flush and slot allocation stay in the top.

## Test plan
- Reset, then dispatch a BNE at rob_index 3 with both operands ready → `issued=1` two edges later, `issue_data.rob_index=3`, `occupancy` 1→0.
- Dispatch ps1=12 not ready; broadcast `wb_tag[1]=12` two cycles later → issue exactly one cycle after the broadcast. Repeat with the broadcast in the dispatch cycle → issues as if ready at dispatch.
- `rob_head=14`; ready entries at rob_index 1, 15, 14 → issue order 14, 15, 1.
- Entries at 2, 5, 7, 9; `curr_rob_tag=10`; `mispredict=1`, `mispredict_tag=5` → 7 and 9 removed, 2 and 5 remain. No issue and `disp_ready=0` that cycle. Repeat with `mispredict_tag=15`, `curr_rob_tag=3`, entries 0, 2, 4 → 0 and 2 removed.
- Fill 4 entries with `fu_b_ready=0` → `disp_ready=0`, `occupancy=4`. Raise `fu_b_ready` → one issue per cycle, and `disp_ready` returns after the first issue.
- Pull `reset` low with 3 valid entries and a pending `issued` → next cycle `issued=0`, `occupancy=0`, and nothing issues after release.
